// File: rtl/i2s_serializer.sv
// i2s_serializer: double-buffered audio frame serializer, Philips I2S or left-justified.
// Optional build macro: I2S_SERIALIZER_UNDERRUN_ZERO_EN sends silence instead of repeating on underrun.
module i2s_serializer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned BCLK_DIV     = 6
) (
  input  logic                             clock_16_934_400,
  input  logic                             reset,
  input  logic [CHANNELS*SAMPLE_WIDTH-1:0] sample_in,
  input  logic                             sample_valid,
  output logic                             sample_ready,
  input  logic                             i2s_mode,
  output logic                             i2s_bit_clock,
  output logic                             i2s_left_right_clock,
  output logic                             i2s_data,
  output logic                             underrun
);

  localparam int unsigned FRAME_W = CHANNELS * SAMPLE_WIDTH;
  localparam int unsigned IDX_W   = $clog2(FRAME_W);
  localparam int unsigned DIV_W   = $clog2(BCLK_DIV);
  localparam int unsigned SLOT_W  = $clog2(CHANNELS);
  localparam int unsigned POS_W   = $clog2(SLOT_WIDTH);

  logic [DIV_W-1:0]   div_cnt;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [POS_W-1:0]   pos_cnt;
  logic [FRAME_W-1:0] hold_buf;
  logic [FRAME_W-1:0] shift_buf;
  logic [FRAME_W-1:0] frame_buf;
  logic               mode_q;
  logic               primed;
  logic               release_pending;
  logic               lj_prev;
  logic               fall;
  logic               boundary;
  logic               take;
  logic               starve;
  logic               mode_eff;
  logic               lj_bit;
  logic [IDX_W-1:0]   lj_idx;

  // slot_cnt/pos_cnt name the bit emitted at the next falling edge; boundary is bit 0.
  // Holding register is full exactly while sample_ready is low (the release cycle never meets a boundary).
  always_comb begin
    fall     = (div_cnt == '0);
    boundary = fall && (slot_cnt == '0) && (pos_cnt == '0);
    take     = boundary && !sample_ready;
    starve   = boundary && sample_ready && primed;
    mode_eff = boundary ? i2s_mode : mode_q;
  end

  // Frame content for this bit: at a boundary, the freshly loaded (or underrun) frame.
  always_comb begin
    frame_buf = shift_buf;
    if (take) begin
      frame_buf = hold_buf;
    end
`ifdef I2S_SERIALIZER_UNDERRUN_ZERO_EN
    else if (starve) begin
      frame_buf = '0;
    end
`endif
  end

  // Left-justified bit: MSB first within the slot, zero padding after the sample.
  always_comb begin
    lj_idx = '0;
    lj_bit = 1'b0;
    if (32'(pos_cnt) < SAMPLE_WIDTH) begin
      lj_idx = IDX_W'(32'(slot_cnt) * SAMPLE_WIDTH + (SAMPLE_WIDTH - 32'd1) - 32'(pos_cnt));
      lj_bit = frame_buf[lj_idx];
    end
  end

  // Bit clock, frame counters and serial outputs.
  always_ff @(posedge clock_16_934_400 or posedge reset) begin
    if (reset) begin
      div_cnt              <= '0;
      slot_cnt             <= '0;
      pos_cnt              <= '0;
      shift_buf            <= '0;
      mode_q               <= 1'b0;
      lj_prev              <= 1'b0;
      i2s_bit_clock        <= 1'b0;
      i2s_left_right_clock <= 1'b0;
      i2s_data             <= 1'b0;
      underrun             <= 1'b0;
    end else begin
      div_cnt       <= (div_cnt == DIV_W'(BCLK_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      i2s_bit_clock <= (32'(div_cnt) >= BCLK_DIV / 2);
      underrun      <= starve;
      if (boundary) begin
        mode_q    <= i2s_mode;
        shift_buf <= frame_buf;
      end
      if (fall) begin
        i2s_left_right_clock <= (32'(slot_cnt) >= CHANNELS / 2);
        i2s_data             <= mode_eff ? lj_prev : lj_bit;
        lj_prev              <= lj_bit;
        if (pos_cnt == POS_W'(SLOT_WIDTH - 1)) begin
          pos_cnt  <= '0;
          slot_cnt <= (slot_cnt == SLOT_W'(CHANNELS - 1)) ? '0 : slot_cnt + SLOT_W'(1);
        end else begin
          pos_cnt <= pos_cnt + POS_W'(1);
        end
      end
    end
  end

  // Holding register handshake; ready returns one edge after the boundary transfer.
  always_ff @(posedge clock_16_934_400 or posedge reset) begin
    if (reset) begin
      hold_buf        <= '0;
      sample_ready    <= 1'b1;
      primed          <= 1'b0;
      release_pending <= 1'b0;
    end else begin
      release_pending <= take;
      if (release_pending) begin
        sample_ready <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        hold_buf     <= sample_in;
        sample_ready <= 1'b0;
        primed       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_serializer.sv
// tb_i2s_serializer: randomized bench for i2s_serializer against a frame-level reference model.
// Also exercises a 4-channel, 24-bit, BCLK_DIV=2 instance with directed checks.
module tb_i2s_serializer;

  localparam int SW   = 16;
  localparam int SLW  = 32;
  localparam int CH   = 2;
  localparam int DIV  = 6;
  localparam int NB   = CH * SLW;
  localparam int FC   = NB * DIV;
  localparam int SW4  = 24;
  localparam int CH4  = 4;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [CH*SW-1:0]  din;
  logic              valid;
  logic              mode;
  logic              ready;
  logic              bclk;
  logic              lrclk;
  logic              data;
  logic              ur;

  i2s_serializer dut (
    .clock_16_934_400     (clk),
    .reset                (rst),
    .sample_in            (din),
    .sample_valid         (valid),
    .sample_ready         (ready),
    .i2s_mode             (mode),
    .i2s_bit_clock        (bclk),
    .i2s_left_right_clock (lrclk),
    .i2s_data             (data),
    .underrun             (ur)
  );

  logic               rst4;
  logic [CH4*SW4-1:0] din4;
  logic               valid4;
  logic               mode4;
  logic               ready4;
  logic               bclk4;
  logic               lrclk4;
  logic               data4;
  logic               ur4;
  logic               done4 = 1'b0;

  i2s_serializer #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(24), .CHANNELS(4), .BCLK_DIV(2)) dut4 (
    .clock_16_934_400     (clk),
    .reset                (rst4),
    .sample_in            (din4),
    .sample_valid         (valid4),
    .sample_ready         (ready4),
    .i2s_mode             (mode4),
    .i2s_bit_clock        (bclk4),
    .i2s_left_right_clock (lrclk4),
    .i2s_data             (data4),
    .underrun             (ur4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame-level view of the stream, indexed by edges since reset release.
  int              m_t;
  int              m_move_t;
  int              m_b;
  logic            m_fall;
  logic            m_acc;
  logic            m_ready;
  logic            m_primed;
  logic            m_hold_full;
  logic            m_mode;
  logic [CH*SW-1:0] m_cur;
  logic [CH*SW-1:0] m_prev;
  logic [CH*SW-1:0] m_hold;
  logic            e_bclk;
  logic            e_lr;
  logic            e_data;
  logic            e_ur;

  // Bench-side observations of the main DUT.
  logic [63:0] cap;
  logic [63:0] lrcap;
  logic [63:0] last_cap;
  logic [63:0] last_lr;
  logic        prev_lr;
  int          last_fall;
  int          frame_len;
  int          ur_cnt;
  int          rdy_cnt;

  function automatic logic lj(input logic [CH*SW-1:0] fr, input int b);
    int s;
    int k;
    logic [CH*SW-1:0] sh;
    s = b / SLW;
    k = b % SLW;
    if (k >= SW) return 1'b0;
    sh = fr >> (s * SW + SW - 1 - k);
    return sh[0];
  endfunction

  task automatic model_reset();
    m_t = 0; m_move_t = -10; m_b = 0; m_fall = 1'b0; m_acc = 1'b0;
    m_ready = 1'b1; m_primed = 1'b0; m_hold_full = 1'b0; m_mode = 1'b0;
    m_cur = '0; m_prev = '0; m_hold = '0;
    e_bclk = 1'b0; e_lr = 1'b0; e_data = 1'b0; e_ur = 1'b0;
    prev_lr = 1'b0; last_fall = -1; frame_len = 0;
  endtask

  task automatic model_edge(input logic v, input logic [CH*SW-1:0] d, input logic md);
    logic bnd;
    bnd   = (m_t % FC) == 0;
    m_acc = v && m_ready;
    e_ur  = 1'b0;
    if (bnd) begin
      m_mode = md;
      m_prev = m_cur;
      if (m_hold_full) begin
        m_cur = m_hold;
        m_hold_full = 1'b0;
        m_move_t = m_t;
      end else if (m_primed) begin
        e_ur = 1'b1;
`ifdef I2S_SERIALIZER_UNDERRUN_ZERO_EN
        m_cur = '0;
`endif
      end
    end
    if (m_t == m_move_t + 1) m_ready = 1'b1;
    if (m_acc) begin
      m_hold = d; m_hold_full = 1'b1; m_ready = 1'b0; m_primed = 1'b1;
    end
    e_bclk = (m_t % DIV) >= DIV / 2;
    m_fall = (m_t % DIV) == 0;
    if (m_fall) begin
      m_b    = (m_t / DIV) % NB;
      e_lr   = m_b >= NB / 2;
      if (m_mode) e_data = (m_b == 0) ? lj(m_prev, NB - 1) : lj(m_cur, m_b - 1);
      else        e_data = lj(m_cur, m_b);
    end
    m_t++;
  endtask

  task automatic tick();
    logic v;
    logic md;
    logic [CH*SW-1:0] d;
    v = valid; d = din; md = mode;
    @(posedge clk);
    #1;
    model_edge(v, d, md);
    check("bclk_lr_data_rdy_ur", 64'({bclk, lrclk, data, ready, ur}),
          64'({e_bclk, e_lr, e_data, m_ready, e_ur}));
    if (m_fall) begin
      if (m_b == 0) begin
        last_cap = cap;
        last_lr  = lrcap;
      end
      cap[63 - m_b]   = data;
      lrcap[63 - m_b] = lrclk;
    end
    if (prev_lr && !lrclk) begin
      frame_len = (m_t - 1) - last_fall;
      last_fall = m_t - 1;
    end
    prev_lr = lrclk;
    ur_cnt  += int'(ur);
    rdy_cnt += int'(ready);
  endtask

  task automatic run_to(input int target);
    while (m_t < target) tick();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Main instance: directed scenarios followed by randomized traffic.
  initial begin : main_seq
    int k;
    cap = '0; lrcap = '0; last_cap = '0; last_lr = '0; ur_cnt = 0; rdy_cnt = 0;
    rst = 1'b1; valid = 1'b0; din = '0; mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'({bclk, lrclk, data, ready, ur}), 64'(5'b00010));

    release_reset();
    valid = 1'b1; din = 32'h0001_A5F0; mode = 1'b0;
    tick();
    valid = 1'b0;
    run_to(2 * FC + 1);
    check("lj_frame_data", last_cap, 64'hA5F0_0000_0001_0000);
    check("lj_frame_lrclk", last_lr, 64'h0000_0000_FFFF_FFFF);
    check("frame_cycles", 64'(frame_len), 64'(FC));

    ur_cnt = 0;
    run_to(4 * FC + 1);
    check("underrun_per_frame", 64'(ur_cnt), 64'd2);
`ifdef I2S_SERIALIZER_UNDERRUN_ZERO_EN
    check("underrun_frame", last_cap, 64'h0);
`else
    check("underrun_frame", last_cap, 64'hA5F0_0000_0001_0000);
`endif

    // Mode switches mid-frame; it applies from the next boundary only.
    run_to(4 * FC + 101);
    mode = 1'b1; valid = 1'b1; din = 32'h0001_A5F0;
    tick();
    valid = 1'b0;
    run_to(6 * FC + 1);
    check("i2s_frame_data", last_cap, 64'h52F8_0000_0000_8000);
    check("i2s_frame_lrclk", last_lr, 64'h0000_0000_FFFF_FFFF);

    // Continuous valid: one accept per frame, ready high one cycle per frame.
    mode = 1'($urandom_range(0, 1));
    valid = 1'b1; din = $urandom;
    run_to(8 * FC + FC / 2);
    rdy_cnt = 0; ur_cnt = 0;
    while (m_t < 11 * FC + FC / 2) begin
      tick();
      if (m_acc) din = $urandom;
    end
    check("stream_ready_cycles", 64'(rdy_cnt), 64'd3);
    check("stream_underruns", 64'(ur_cnt), 64'd0);

    // Random valid/data/mode traffic.
    while (m_t < 18 * FC) begin
      tick();
      if (valid && m_acc) begin
        valid = 1'($urandom_range(0, 1));
        din = $urandom;
      end else if (!valid && $urandom_range(0, 199) == 0) begin
        valid = 1'b1;
        din = $urandom;
      end
      if ($urandom_range(0, 499) == 0) mode = ~mode;
    end

    // Sample accepted in the boundary cycle itself: this frame underruns, next one carries it.
    valid = 1'b0;
    k = m_t / FC + 2;
    run_to(k * FC);
    valid = 1'b1; din = $urandom;
    tick();
    valid = 1'b0;
    check("boundary_accept_underrun", 64'(ur), 64'd1);
    check("boundary_accept_ready", 64'(ready), 64'd0);
    run_to((k + 1) * FC + 1);
    check("boundary_accept_next_ur", 64'(ur), 64'd0);

    // Reset asserted at b = 20 clears outputs immediately.
    k = m_t / FC + 1;
    run_to(k * FC + 20 * DIV + 1);
    rst = 1'b1;
    #1;
    check("reset_mid_frame", 64'({bclk, lrclk, data, ready, ur}), 64'(5'b00010));
    repeat (3) @(posedge clk);
    release_reset();
    ur_cnt = 0;
    run_to(2 * FC + 1);
    check("post_reset_underruns", 64'(ur_cnt), 64'd0);

    for (int i = 0; i < 5000 && !done4; i++) @(posedge clk);
    check("ch4_done", 64'(done4), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Four-channel instance: slot order, lrclk split and frame length.
  initial begin : ch4_seq
    logic [CH4*SW4-1:0] capd;
    logic [CH4*SW4-1:0] capl;
    logic prev_l;
    logic prev_b;
    int   bit_i;
    int   cyc;
    int   n;
    logic found;
    capd = '0; capl = '0; bit_i = 0; cyc = 0;
    rst4 = 1'b1; valid4 = 1'b0; din4 = '0; mode4 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst4 = 1'b0;
    din4 = {$urandom, $urandom, $urandom};
    valid4 = 1'b1;
    n = 0;
    while (!ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    valid4 = 1'b0;

    found = 1'b0;
    prev_l = lrclk4;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (prev_l && !lrclk4) found = 1'b1;
      prev_l = lrclk4;
    end
    check("ch4_first_frame_seen", 64'(found), 64'd1);
    check("ch4_ur_on_load", 64'(ur4), 64'd0);

    found = 1'b0;
    prev_b = bclk4;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      cyc++;
      if (!prev_b && bclk4 && bit_i < CH4 * SW4) begin
        capd[CH4 * SW4 - 1 - bit_i] = data4;
        capl[CH4 * SW4 - 1 - bit_i] = lrclk4;
        bit_i++;
      end
      if (prev_l && !lrclk4) found = 1'b1;
      prev_b = bclk4;
      prev_l = lrclk4;
    end
    check("ch4_frame_cycles", 64'(cyc), 64'd192);
    check("ch4_bits", 64'(bit_i), 64'd96);
    check("ch4_ur_repeat", 64'(ur4), 64'd1);
    check("ch4_lr_slots01", 64'(capl[95:48]), 64'h0);
    check("ch4_lr_slots23", 64'(capl[47:0]), 64'hFFFF_FFFF_FFFF);
    for (int c = 0; c < CH4; c++) begin
      check("ch4_slot", 64'(capd[95 - 24 * c -: 24]), 64'(din4[24 * c +: 24]));
    end
    done4 = 1'b1;
  end

endmodule
